// File: rtl/pc_sequencer.sv
// pc_sequencer: PC register and two-cycle fetch/step sequencer feeding a registered jump-target LUT.
// Define INSTR_COUNT_EN to add the retired-instruction counter port instr_count.
module pc_sequencer #(
  parameter int D = 12
`ifdef INSTR_COUNT_EN
  ,
  parameter int CW = 16
`endif
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [D-1:0]  start_addr,
  input  logic          stall,
  input  logic          jump_taken,
  input  logic          halt_req,
  input  logic [D-1:0]  lut_target,
  output logic [D-1:0]  lut_addr,
  output logic          lut_jump,
  output logic [D-1:0]  pc,
  output logic          instr_valid,
  output logic          busy,
  output logic          done
`ifdef INSTR_COUNT_EN
  ,
  output logic [CW-1:0] instr_count
`endif
);
  typedef enum logic [1:0] {IDLE, FETCH, STEP, HALTED} state_t;
  state_t r_state, w_state;
  logic [D-1:0] r_pc, w_pc;
  always_comb begin
    w_state = r_state;
    w_pc = r_pc;
    case (r_state)
      IDLE, HALTED: if (start) begin
        w_state = FETCH;
        w_pc = start_addr;
      end
      FETCH: if (!stall) w_state = halt_req ? HALTED : STEP;
      STEP: begin
        w_state = FETCH;
        w_pc = lut_target;
      end
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_pc <= '0;
    end else begin
      r_state <= w_state;
      r_pc <= w_pc;
    end
  end
  assign pc = r_pc;
  assign lut_addr = r_pc;
  assign lut_jump = jump_taken & (r_state == FETCH);
  assign instr_valid = r_state == FETCH;
  assign busy = (r_state == FETCH) | (r_state == STEP);
  assign done = r_state == HALTED;
`ifdef INSTR_COUNT_EN
  logic [CW-1:0] r_cnt;
  logic w_start, w_retire;
  assign w_start = start & ((r_state == IDLE) | (r_state == HALTED));
  // a HALT retires as it leaves FETCH; every other instruction retires leaving STEP
  assign w_retire = (r_state == STEP) | ((r_state == FETCH) & !stall & halt_req);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_cnt <= '0;
    else if (w_start) r_cnt <= '0;
    else if (w_retire) r_cnt <= r_cnt + 1'b1;
  end
  assign instr_count = r_cnt;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vector table, hand-written reset/wrap sequences and a randomized run against a behavioural model.
module tb_pc_sequencer;
  localparam int D = 12;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, stall = 1'b0, jump_taken = 1'b0, halt_req = 1'b0;
  logic [D-1:0] start_addr = '0, lut_target = '0;
  logic [D-1:0] lut_addr, pc;
  logic lut_jump, instr_valid, busy, done;
`ifdef INSTR_COUNT_EN
  logic [15:0] instr_count;
`endif
  int n_chk = 0, n_pass = 0;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .stall(stall),
    .jump_taken(jump_taken), .halt_req(halt_req), .lut_target(lut_target),
    .lut_addr(lut_addr), .lut_jump(lut_jump), .pc(pc), .instr_valid(instr_valid),
    .busy(busy), .done(done)
`ifdef INSTR_COUNT_EN
    , .instr_count(instr_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic st; logic [D-1:0] sa; logic sl, j, h; logic [D-1:0] lt;
    logic [D-1:0] pc; logic v, b, d, lj; int cnt;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic [D-1:0] sa, input logic sl, j, h,
                              input logic [D-1:0] lt, input logic [D-1:0] epc,
                              input logic v, b, d, lj, input int cnt);
    vec_t r;
    r.st = st; r.sa = sa; r.sl = sl; r.j = j; r.h = h; r.lt = lt;
    r.pc = epc; r.v = v; r.b = b; r.d = d; r.lj = lj; r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic chk_out(input string tag, input logic [D-1:0] epc, input logic ev, eb, ed, elj);
    chk({tag, " pc"}, int'(pc), int'(epc));
    chk({tag, " lut_addr"}, int'(lut_addr), int'(epc));
    chk({tag, " instr_valid"}, int'(instr_valid), int'(ev));
    chk({tag, " busy"}, int'(busy), int'(eb));
    chk({tag, " done"}, int'(done), int'(ed));
    chk({tag, " lut_jump"}, int'(lut_jump), int'(elj));
  endtask

  task automatic chk_cnt(input string tag, input int e);
`ifdef INSTR_COUNT_EN
    chk({tag, " instr_count"}, int'(instr_count), e);
`else
    if (e < 0) $display("negative count expectation in %s", tag);
`endif
  endtask

  task automatic drive(input logic st, input logic [D-1:0] sa, input logic sl, j, h,
                       input logic [D-1:0] lt);
    @(negedge clk);
    start = st; start_addr = sa; stall = sl; jump_taken = j; halt_req = h; lut_target = lt;
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0; stall = 1'b0; jump_taken = 1'b0; halt_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  vec_t tv[22];
  logic [D-1:0] m_pc;
  logic m_fetch, m_step, m_halt;
  int m_cnt;

  initial begin
    tv[0]  = mk(1, 12'h000, 0, 0, 0, 12'h000, 12'h000, 0, 0, 0, 0, 0);
    tv[1]  = mk(0, 12'h000, 0, 0, 0, 12'h000, 12'h000, 1, 1, 0, 0, 0);
    tv[2]  = mk(0, 12'h000, 0, 0, 0, 12'h001, 12'h000, 0, 1, 0, 0, 0);
    tv[3]  = mk(0, 12'h000, 0, 0, 0, 12'h000, 12'h001, 1, 1, 0, 0, 1);
    tv[4]  = mk(0, 12'h000, 0, 0, 0, 12'h002, 12'h001, 0, 1, 0, 0, 1);
    tv[5]  = mk(0, 12'h000, 0, 0, 0, 12'h000, 12'h002, 1, 1, 0, 0, 2);
    tv[6]  = mk(0, 12'h000, 0, 0, 0, 12'h003, 12'h002, 0, 1, 0, 0, 2);
    tv[7]  = mk(1, 12'h100, 0, 0, 0, 12'h000, 12'h003, 1, 1, 0, 0, 3);
    tv[8]  = mk(1, 12'h100, 0, 0, 0, 12'h004, 12'h003, 0, 1, 0, 0, 3);
    tv[9]  = mk(0, 12'h000, 0, 1, 0, 12'h000, 12'h004, 1, 1, 0, 1, 4);
    tv[10] = mk(0, 12'h000, 0, 1, 0, 12'h003, 12'h004, 0, 1, 0, 0, 4);
    tv[11] = mk(0, 12'h000, 0, 1, 0, 12'h000, 12'h003, 1, 1, 0, 1, 5);
    tv[12] = mk(0, 12'h000, 0, 0, 0, 12'h020, 12'h003, 0, 1, 0, 0, 5);
    tv[13] = mk(0, 12'h000, 1, 0, 1, 12'h000, 12'h020, 1, 1, 0, 0, 6);
    tv[14] = mk(0, 12'h000, 1, 0, 0, 12'h000, 12'h020, 1, 1, 0, 0, 6);
    tv[15] = mk(0, 12'h000, 1, 0, 0, 12'h055, 12'h020, 1, 1, 0, 0, 6);
    tv[16] = mk(0, 12'h000, 0, 0, 0, 12'h000, 12'h020, 1, 1, 0, 0, 6);
    tv[17] = mk(0, 12'h000, 1, 0, 0, 12'h030, 12'h020, 0, 1, 0, 0, 6);
    tv[18] = mk(0, 12'h000, 0, 1, 1, 12'h000, 12'h030, 1, 1, 0, 1, 7);
    tv[19] = mk(0, 12'h000, 0, 0, 0, 12'h000, 12'h030, 0, 0, 1, 0, 8);
    tv[20] = mk(1, 12'h100, 0, 0, 0, 12'h000, 12'h030, 0, 0, 1, 0, 8);
    tv[21] = mk(0, 12'h000, 0, 0, 0, 12'h000, 12'h100, 1, 1, 0, 0, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk_out("reset", 12'h000, 0, 0, 0, 0);
    chk_cnt("reset", 0);
    reset = 1'b0;

    for (int i = 0; i < 22; i++) begin
      drive(tv[i].st, tv[i].sa, tv[i].sl, tv[i].j, tv[i].h, tv[i].lt);
      chk_out($sformatf("vec%0d", i), tv[i].pc, tv[i].v, tv[i].b, tv[i].d, tv[i].lj);
      chk_cnt($sformatf("vec%0d", i), tv[i].cnt);
      @(posedge clk);
    end

    // reset mid-instruction: reach STEP at 0x010, then assert reset asynchronously
    pulse_reset();
    drive(1, 12'h00F, 0, 0, 0, 12'h000); @(posedge clk);
    drive(0, 12'h000, 0, 0, 0, 12'h000); @(posedge clk);
    drive(0, 12'h000, 0, 0, 0, 12'h010); @(posedge clk);
    drive(0, 12'h000, 0, 0, 0, 12'h000); @(posedge clk);
    drive(0, 12'h000, 0, 0, 0, 12'h055);
    chk_out("pre_rst", 12'h010, 0, 1, 0, 0);
    reset = 1'b1;
    #1;
    chk_out("mid_rst", 12'h000, 0, 0, 0, 0);
    chk_cnt("mid_rst", 0);
    @(posedge clk);
    #1;
    chk_out("rst_hold", 12'h000, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0; start = 1'b1; start_addr = 12'h200;
    @(posedge clk);
    #1;
    chk_out("rst_release", 12'h200, 1, 1, 0, 0);
    chk_cnt("rst_release", 0);

    // wrap through 0xFFF with a +1 LUT, then halt
    pulse_reset();
    drive(1, 12'hFFE, 0, 0, 0, 12'h000); @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      logic [D-1:0] e;
      e = 12'hFFE + k[D-1:0];
      drive(0, 12'h000, 0, 0, 0, 12'h000);
      chk_out($sformatf("wrap_f%0d", k), e, 1, 1, 0, 0);
      @(posedge clk);
      drive(0, 12'h000, 0, 0, 0, e + 12'h001);
      @(posedge clk);
    end
    drive(0, 12'h000, 0, 0, 1, 12'h000);
    chk_out("wrap_halt", 12'h001, 1, 1, 0, 0);
    @(posedge clk);
    drive(0, 12'h000, 0, 0, 0, 12'h000);
    chk_out("wrap_done", 12'h001, 0, 0, 1, 0);
    chk_cnt("wrap_done", 4);

    // randomized run against a behavioural model
    pulse_reset();
    m_pc = '0; m_fetch = 0; m_step = 0; m_halt = 0; m_cnt = 0;
    for (int i = 0; i < 600; i++) begin
      logic st, sl, j, h;
      logic [D-1:0] sa, lt;
      st = $urandom_range(0, 5) == 0;
      sl = $urandom_range(0, 3) == 0;
      j = $urandom_range(0, 1) == 1;
      h = $urandom_range(0, 7) == 0;
      sa = D'($urandom);
      lt = D'($urandom);
      drive(st, sa, sl, j, h, lt);
      chk_out($sformatf("rnd%0d", i), m_pc, m_fetch, m_fetch | m_step, m_halt, j & m_fetch);
      chk_cnt($sformatf("rnd%0d", i), m_cnt);
      @(posedge clk);
      if (m_fetch) begin
        if (!sl) begin
          m_fetch = 0;
          if (h) begin m_halt = 1; m_cnt = (m_cnt + 1) % 65536; end
          else m_step = 1;
        end
      end else if (m_step) begin
        m_pc = lt; m_step = 0; m_fetch = 1; m_cnt = (m_cnt + 1) % 65536;
      end else if (st) begin
        m_pc = sa; m_fetch = 1; m_halt = 0; m_cnt = 0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
